memory_cycle_lsu: RTL and testbench

- Memory-access stage of the RV32I pipeline; sits between the execute/memory pipeline register and the writeback stage.
- Performs loads and stores over a req/ack data-memory bus and generates byte enables.
- Aligns and extends load data, stalls upstream while a bus access is outstanding, and registers all results into the M/W pipeline register that feeds writeback.

---
 rtl/memory_cycle_lsu_if.sv | 38 +++
 rtl/memory_cycle_lsu.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_memory_cycle_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_lsu_if.sv
//------------------------------------------------------------------------------
// Module   : memory_cycle_lsu_if
// Purpose  : Data-memory req/ack bus between the memory-access stage and the
//            data memory.
// Signals  : dmem_req   - bus request, held until dmem_ack
//            dmem_we    - 1 = write, 0 = read
//            dmem_addr  - word-aligned byte address
//            dmem_wdata - lane-replicated store data
//            dmem_be    - byte enables
//            dmem_ack   - access complete, dmem_rdata valid
//            dmem_rdata - read word
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface memory_cycle_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  // Memory-stage side: issues requests.
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  // Memory side: answers requests.
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/memory_cycle_lsu.sv
//------------------------------------------------------------------------------
// Module   : memory_cycle_lsu
// Purpose  : RV32I memory-access stage. Issues loads/stores on the req/ack
//            data bus, aligns and extends load data, stalls upstream while an
//            access is outstanding and registers results into the M/W
//            pipeline register.
// Ports    : clk, rst (async, active-low)
//            *M inputs    - instruction in the memory stage
//            stall_M      - combinational hold of the upstream pipeline
//            dmem         - data-memory bus (master side)
//            *W outputs   - registered results for writeback
//            misalign_err - one-cycle pulse, misaligned or illegal access
//            bus_err      - one-cycle pulse, ack timeout
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memory_cycle_lsu #(
  parameter int ACK_TIMEOUT = 64
) (
  input  wire         clk,
  input  wire         rst,
  input  wire         RegWriteM,
  input  wire         MemReadM,
  input  wire         MemWriteM,
  input  wire  [1:0]  ResultSrcM,
  input  wire  [4:0]  RD_M,
  input  wire  [2:0]  funct3M,
  input  wire  [31:0] ALU_ResultM,
  input  wire  [31:0] WriteDataM,
  input  wire  [31:0] PCPlus4M,
  output logic        stall_M,
  memory_cycle_lsu_if.master dmem,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bus drivers
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  // Copy of the instruction taken at issue, used at completion
  logic        h_regwrite_q, h_regwrite_d;
  logic        h_store_q, h_store_d;
  logic [1:0]  h_resultsrc_q, h_resultsrc_d;
  logic [4:0]  h_rd_q, h_rd_d;
  logic [2:0]  h_funct3_q, h_funct3_d;
  logic [31:0] h_alu_q, h_alu_d;
  logic [31:0] h_pc4_q, h_pc4_d;

  // M/W pipeline register
  logic        regwrite_w_q, regwrite_w_d;
  logic [1:0]  resultsrc_w_q, resultsrc_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] alu_w_q, alu_w_d;
  logic [31:0] rdata_w_q, rdata_w_d;
  logic [31:0] pc4_w_q, pc4_w_d;
  logic        misalign_q, misalign_d;
  logic        buserr_q, buserr_d;

  logic        memop;
  logic        legal;
  logic        size_ok;
  logic        op_ok;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign memop = MemReadM | MemWriteM;

  // Access legality: alignment by size, and funct3 allowed for the direction.
  always_comb begin
    size_ok = 1'b0;
    op_ok   = 1'b0;
    case (funct3M)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: size_ok = ~ALU_ResultM[0];
      3'b010:         size_ok = (ALU_ResultM[1:0] == 2'b00);
      default:        size_ok = 1'b0;
    endcase
    if (MemWriteM) begin
      op_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    end else begin
      op_ok = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
              (funct3M == 3'b100) || (funct3M == 3'b101);
    end
    legal = size_ok & op_ok;
  end

  // Lane extraction of the returned word using the held address.
  always_comb begin
    lane_byte = 8'h00;
    load_data = 32'h0;
    case (h_alu_q[1:0])
      2'd0:    lane_byte = dmem.dmem_rdata[7:0];
      2'd1:    lane_byte = dmem.dmem_rdata[15:8];
      2'd2:    lane_byte = dmem.dmem_rdata[23:16];
      default: lane_byte = dmem.dmem_rdata[31:24];
    endcase
    lane_half = h_alu_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (h_funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_data = dmem.dmem_rdata;
      3'b100:  load_data = {24'h0, lane_byte};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    h_regwrite_d  = h_regwrite_q;
    h_store_d     = h_store_q;
    h_resultsrc_d = h_resultsrc_q;
    h_rd_d        = h_rd_q;
    h_funct3_d    = h_funct3_q;
    h_alu_d       = h_alu_q;
    h_pc4_d       = h_pc4_q;
    // Default W contents are a bubble
    regwrite_w_d  = 1'b0;
    resultsrc_w_d = 2'b00;
    rd_w_d        = 5'd0;
    alu_w_d       = 32'h0;
    rdata_w_d     = 32'h0;
    pc4_w_d       = 32'h0;
    misalign_d    = 1'b0;
    buserr_d      = 1'b0;
    stall_M       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!memop) begin
          regwrite_w_d  = RegWriteM;
          resultsrc_w_d = ResultSrcM;
          rd_w_d        = RD_M;
          alu_w_d       = ALU_ResultM;
          pc4_w_d       = PCPlus4M;
        end else if (legal) begin
          stall_M       = 1'b1;
          req_d         = 1'b1;
          we_d          = MemWriteM;
          addr_d        = {ALU_ResultM[31:2], 2'b00};
          cnt_d         = '0;
          state_d       = BUSY;
          h_regwrite_d  = RegWriteM;
          h_store_d     = MemWriteM;
          h_resultsrc_d = ResultSrcM;
          h_rd_d        = RD_M;
          h_funct3_d    = funct3M;
          h_alu_d       = ALU_ResultM;
          h_pc4_d       = PCPlus4M;
          if (MemWriteM) begin
            case (funct3M[1:0])
              2'b00: begin
                be_d    = 4'b0001 << ALU_ResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
              end
              2'b01: begin
                be_d    = 4'b0011 << ALU_ResultM[1:0];
                wdata_d = {2{WriteDataM[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
              end
            endcase
          end else begin
            be_d    = 4'b1111;
            wdata_d = 32'h0;
          end
        end else begin
          // Rejected access still retires, but must not write a register
          misalign_d    = 1'b1;
          resultsrc_w_d = ResultSrcM;
          rd_w_d        = RD_M;
          alu_w_d       = ALU_ResultM;
          pc4_w_d       = PCPlus4M;
        end
      end

      BUSY: begin
        stall_M = ~dmem.dmem_ack;
        // Ack is tested first so it wins over a coincident timeout
        if (dmem.dmem_ack) begin
          req_d         = 1'b0;
          state_d       = IDLE;
          regwrite_w_d  = h_regwrite_q;
          resultsrc_w_d = h_resultsrc_q;
          rd_w_d        = h_rd_q;
          alu_w_d       = h_alu_q;
          pc4_w_d       = h_pc4_q;
          rdata_w_d     = h_store_q ? 32'h0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          req_d         = 1'b0;
          state_d       = IDLE;
          buserr_d      = 1'b1;
          resultsrc_w_d = h_resultsrc_q;
          rd_w_d        = h_rd_q;
          alu_w_d       = h_alu_q;
          pc4_w_d       = h_pc4_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      be_q          <= 4'h0;
      h_regwrite_q  <= 1'b0;
      h_store_q     <= 1'b0;
      h_resultsrc_q <= 2'b00;
      h_rd_q        <= 5'd0;
      h_funct3_q    <= 3'b000;
      h_alu_q       <= 32'h0;
      h_pc4_q       <= 32'h0;
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= 2'b00;
      rd_w_q        <= 5'd0;
      alu_w_q       <= 32'h0;
      rdata_w_q     <= 32'h0;
      pc4_w_q       <= 32'h0;
      misalign_q    <= 1'b0;
      buserr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      h_regwrite_q  <= h_regwrite_d;
      h_store_q     <= h_store_d;
      h_resultsrc_q <= h_resultsrc_d;
      h_rd_q        <= h_rd_d;
      h_funct3_q    <= h_funct3_d;
      h_alu_q       <= h_alu_d;
      h_pc4_q       <= h_pc4_d;
      regwrite_w_q  <= regwrite_w_d;
      resultsrc_w_q <= resultsrc_w_d;
      rd_w_q        <= rd_w_d;
      alu_w_q       <= alu_w_d;
      rdata_w_q     <= rdata_w_d;
      pc4_w_q       <= pc4_w_d;
      misalign_q    <= misalign_d;
      buserr_q      <= buserr_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign RegWriteW       = regwrite_w_q;
  assign ResultSrcW      = resultsrc_w_q;
  assign RD_W            = rd_w_q;
  assign ALU_ResultW     = alu_w_q;
  assign ReadDataW       = rdata_w_q;
  assign PCPlus4W        = pc4_w_q;
  assign misalign_err    = misalign_q;
  assign bus_err         = buserr_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_cycle_lsu.sv
//------------------------------------------------------------------------------
// Module   : tb_memory_cycle_lsu
// Purpose  : Directed self-checking bench for memory_cycle_lsu. Expected
//            writeback records are queued at issue and popped at retirement.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_memory_cycle_lsu;

  localparam int ACK_TIMEOUT = 4;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [4:0]  RD_M = 5'd0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALU_ResultM = 32'h0, WriteDataM = 32'h0, PCPlus4M = 32'h0;
  logic        stall_M;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
  logic        misalign_err, bus_err;

  int n_vec  = 0;
  int n_miss = 0;
  wexp_t sb[$];

  memory_cycle_lsu_if ifc ();

  memory_cycle_lsu #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .funct3M     (funct3M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .stall_M     (stall_M),
    .dmem        (ifc),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W),
    .misalign_err(misalign_err),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic rw, input logic mr, input logic mw,
                         input logic [1:0] rs, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
    RegWriteM   = rw;
    MemReadM    = mr;
    MemWriteM   = mw;
    ResultSrcM  = rs;
    RD_M        = rd;
    funct3M     = f3;
    ALU_ResultM = alu;
    WriteDataM  = wd;
    PCPlus4M    = pc4;
  endtask

  task automatic nop();
    drive_m(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic push_exp(input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] rdat,
                          input logic [31:0] pc4);
    wexp_t e;
    e.rw = rw; e.rs = rs; e.rd = rd; e.alu = alu; e.rdat = rdat; e.pc4 = pc4;
    sb.push_back(e);
  endtask

  task automatic check_w(input string tag);
    wexp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_RegWriteW"},   32'(RegWriteW),  32'(e.rw));
      chk({tag, "_ResultSrcW"},  32'(ResultSrcW), 32'(e.rs));
      chk({tag, "_RD_W"},        32'(RD_W),       32'(e.rd));
      chk({tag, "_ALU_ResultW"}, ALU_ResultW,     e.alu);
      chk({tag, "_ReadDataW"},   ReadDataW,       e.rdat);
      chk({tag, "_PCPlus4W"},    PCPlus4W,        e.pc4);
    end
  endtask

  // M inputs for a legal access must already be driven at the current slot.
  // Waits n_wait BUSY cycles without ack, then acks with rdata.
  task automatic run_mem(input string tag, input int n_wait, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         output int stall_hi);
    stall_hi = 0;
    #1;
    if (stall_M) stall_hi++;
    tick();
    chk({tag, "_bubble"}, 32'(RegWriteW), 32'd0);
    for (int i = 0; i < n_wait; i++) begin
      #1;
      if (stall_M) stall_hi++;
      tick();
    end
    ifc.dmem_ack   = 1'b1;
    ifc.dmem_rdata = rdata;
    #1;
    if (stall_M) stall_hi++;
    chk({tag, "_req"},   32'(ifc.dmem_req), 32'd1);
    chk({tag, "_we"},    32'(ifc.dmem_we),  32'(exp_we));
    chk({tag, "_addr"},  ifc.dmem_addr,     exp_addr);
    chk({tag, "_be"},    32'(ifc.dmem_be),  32'(exp_be));
    chk({tag, "_wdata"}, ifc.dmem_wdata,    exp_wdata);
    tick();
    ifc.dmem_ack   = 1'b0;
    ifc.dmem_rdata = 32'h0;
  endtask

  initial begin
    int sh;
    int req_cnt;
    ifc.dmem_ack   = 1'b0;
    ifc.dmem_rdata = 32'h0;

    // Reset state
    #3;
    chk("rst_req",       32'(ifc.dmem_req),   32'd0);
    chk("rst_we",        32'(ifc.dmem_we),    32'd0);
    chk("rst_be",        32'(ifc.dmem_be),    32'd0);
    chk("rst_addr",      ifc.dmem_addr,       32'd0);
    chk("rst_wdata",     ifc.dmem_wdata,      32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW),      32'd0);
    chk("rst_misalign",  32'(misalign_err),   32'd0);
    chk("rst_bus_err",   32'(bus_err),        32'd0);
    chk("rst_stall",     32'(stall_M),        32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ALU op, 1-cycle latency
    drive_m(1'b1, 1'b0, 1'b0, 2'b00, 5'd5, 3'b000, 32'h1234, 32'h0, 32'h44);
    push_exp(1'b1, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h44);
    #1;
    chk("alu_stall", 32'(stall_M), 32'd0);
    tick();
    nop();
    check_w("alu");

    // LB at 0x103, ack on the last counter value before timeout (ack wins)
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd7, 3'b000, 32'h103, 32'h0, 32'h88);
    push_exp(1'b1, 2'b01, 5'd7, 32'h103, 32'hFFFF_FF80, 32'h88);
    run_mem("lb", 3, 32'h80AA_BBCC, 1'b0, 32'h100, 4'b1111, 32'h0, sh);
    nop();
    chk("lb_stall_cycles", 32'(sh), 32'd4);
    chk("lb_bus_err", 32'(bus_err), 32'd0);
    chk("lb_req_drop", 32'(ifc.dmem_req), 32'd0);
    check_w("lb");

    // LBU same address/data
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd8, 3'b100, 32'h103, 32'h0, 32'h8C);
    push_exp(1'b1, 2'b01, 5'd8, 32'h103, 32'h0000_0080, 32'h8C);
    run_mem("lbu", 1, 32'h80AA_BBCC, 1'b0, 32'h100, 4'b1111, 32'h0, sh);
    nop();
    chk("lbu_stall_cycles", 32'(sh), 32'd2);
    check_w("lbu");

    // LH upper half, LHU lower half, LW whole word
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd10, 3'b001, 32'h102, 32'h0, 32'h90);
    push_exp(1'b1, 2'b01, 5'd10, 32'h102, 32'hFFFF_80AA, 32'h90);
    run_mem("lh", 0, 32'h80AA_BBCC, 1'b0, 32'h100, 4'b1111, 32'h0, sh);
    nop();
    check_w("lh");
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd11, 3'b101, 32'h100, 32'h0, 32'h94);
    push_exp(1'b1, 2'b01, 5'd11, 32'h100, 32'h0000_BBCC, 32'h94);
    run_mem("lhu", 0, 32'h80AA_BBCC, 1'b0, 32'h100, 4'b1111, 32'h0, sh);
    nop();
    check_w("lhu");
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd12, 3'b010, 32'h104, 32'h0, 32'h98);
    push_exp(1'b1, 2'b01, 5'd12, 32'h104, 32'hCAFE_F00D, 32'h98);
    run_mem("lw", 2, 32'hCAFE_F00D, 1'b0, 32'h104, 4'b1111, 32'h0, sh);
    nop();
    check_w("lw");

    // SH at 0x102, immediate ack: 2 cycles total
    drive_m(1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 3'b001, 32'h102, 32'hDEAD_BEEF, 32'hA0);
    push_exp(1'b0, 2'b00, 5'd0, 32'h102, 32'h0, 32'hA0);
    run_mem("sh", 0, 32'h1111_2222, 1'b1, 32'h100, 4'b1100, 32'hBEEF_BEEF, sh);
    nop();
    chk("sh_stall_cycles", 32'(sh), 32'd1);
    check_w("sh");

    // SB at 0x101
    drive_m(1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 3'b000, 32'h101, 32'h0000_00AB, 32'hA4);
    push_exp(1'b0, 2'b00, 5'd0, 32'h101, 32'h0, 32'hA4);
    run_mem("sb", 0, 32'h0, 1'b1, 32'h100, 4'b0010, 32'hABAB_ABAB, sh);
    nop();
    check_w("sb");

    // Misaligned LW at 0x101
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd9, 3'b010, 32'h101, 32'h0, 32'hC0);
    push_exp(1'b0, 2'b01, 5'd9, 32'h101, 32'h0, 32'hC0);
    #1;
    chk("mis_stall", 32'(stall_M), 32'd0);
    tick();
    nop();
    chk("mis_req", 32'(ifc.dmem_req), 32'd0);
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    check_w("mis");
    tick();
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);

    // Illegal store funct3 (100) with aligned address
    drive_m(1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 3'b100, 32'h200, 32'h55, 32'hC4);
    push_exp(1'b0, 2'b00, 5'd4, 32'h200, 32'h0, 32'hC4);
    #1;
    chk("ill_stall", 32'(stall_M), 32'd0);
    tick();
    nop();
    chk("ill_req", 32'(ifc.dmem_req), 32'd0);
    chk("ill_pulse", 32'(misalign_err), 32'd1);
    check_w("ill");

    // LW with no ack: timeout after ACK_TIMEOUT BUSY cycles
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd3, 3'b010, 32'h200, 32'h0, 32'hD0);
    push_exp(1'b0, 2'b01, 5'd3, 32'h200, 32'h0, 32'hD0);
    tick();
    req_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!ifc.dmem_req) break;
      req_cnt++;
      tick();
    end
    nop();
    chk("to_req_cycles", 32'(req_cnt), 32'(ACK_TIMEOUT));
    chk("to_bus_err", 32'(bus_err), 32'd1);
    check_w("to");
    ifc.dmem_ack   = 1'b1;
    ifc.dmem_rdata = 32'hFFFF_FFFF;
    tick();
    ifc.dmem_ack   = 1'b0;
    chk("to_bus_err_end", 32'(bus_err), 32'd0);
    chk("to_late_ack_req", 32'(ifc.dmem_req), 32'd0);
    chk("to_late_ack_rw", 32'(RegWriteW), 32'd0);
    drive_m(1'b1, 1'b0, 1'b0, 2'b10, 5'd6, 3'b000, 32'h77, 32'h0, 32'hD8);
    push_exp(1'b1, 2'b10, 5'd6, 32'h77, 32'h0, 32'hD8);
    #1;
    chk("resume_stall", 32'(stall_M), 32'd0);
    tick();
    nop();
    check_w("resume");

    // Reset during BUSY of an SW
    drive_m(1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 3'b010, 32'h300, 32'h1234_5678, 32'hE0);
    tick();
    chk("rb_req_pre",  32'(ifc.dmem_req), 32'd1);
    chk("rb_addr_pre", ifc.dmem_addr,     32'h300);
    #2;
    rst = 1'b0;
    #1;
    chk("rb_req",   32'(ifc.dmem_req), 32'd0);
    chk("rb_we",    32'(ifc.dmem_we),  32'd0);
    chk("rb_addr",  ifc.dmem_addr,     32'd0);
    chk("rb_be",    32'(ifc.dmem_be),  32'd0);
    chk("rb_wdata", ifc.dmem_wdata,    32'd0);
    chk("rb_pc4w",  PCPlus4W,          32'd0);
    nop();
    ifc.dmem_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    ifc.dmem_ack = 1'b0;
    chk("rb_late_ack_req", 32'(ifc.dmem_req), 32'd0);
    drive_m(1'b1, 1'b1, 1'b0, 2'b01, 5'd13, 3'b010, 32'h400, 32'h0, 32'hF0);
    push_exp(1'b1, 2'b01, 5'd13, 32'h400, 32'h0BAD_CAFE, 32'hF0);
    run_mem("post_rst", 2, 32'h0BAD_CAFE, 1'b0, 32'h400, 4'b1111, 32'h0, sh);
    nop();
    chk("post_rst_stall_cycles", 32'(sh), 32'd3);
    check_w("post_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
